// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: PC sequencer and instruction-fetch front end with req/ready memory handshake
// and a one-entry skid buffer that absorbs a word returned while decode is stalled.
module pc_fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc_plus4,
   output logic        addr_err
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n, addr_n, instr_n, pc4_n, skid_instr, skid_pc4, skid_instr_n, skid_pc4_n;
   logic        valid_n, skid_v, skid_v_n;
   logic        redir, done;
   logic [31:0] tgt, tgt_al, pc4;
   assign redir    = jump_en | br_taken;
   assign tgt      = jump_en ? jump_target : br_target;
   assign tgt_al   = {tgt[31:2], 2'b00};
   assign pc4      = pc + 32'd4;
   assign imem_req = (state == FETCH) || (state == DRAIN);
   assign done     = imem_req & imem_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_addr   <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc_plus4 <= '0;
         skid_v      <= 1'b0;
         skid_instr  <= '0;
         skid_pc4    <= '0;
         addr_err    <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         imem_addr   <= addr_n;
         if_valid    <= valid_n;
         if_instr    <= instr_n;
         if_pc_plus4 <= pc4_n;
         skid_v      <= skid_v_n;
         skid_instr  <= skid_instr_n;
         skid_pc4    <= skid_pc4_n;
         addr_err    <= redir & (|tgt[1:0]);
      end
   end
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      addr_n       = imem_addr;
      valid_n      = if_valid & stall;
      instr_n      = if_instr;
      pc4_n        = if_pc_plus4;
      skid_v_n     = skid_v;
      skid_instr_n = skid_instr;
      skid_pc4_n   = skid_pc4;
      case (state)
         IDLE: begin
            state_n = FETCH;
            pc_n    = redir ? tgt_al : pc;
            addr_n  = redir ? tgt_al : pc;
         end
         FETCH: begin
            if (redir) begin
               pc_n    = tgt_al;
               addr_n  = done ? tgt_al : imem_addr;
               state_n = done ? FETCH : DRAIN;
            end else if (done && (!stall || !if_valid)) begin
               instr_n = imem_rdata;
               pc4_n   = pc4;
               valid_n = 1'b1;
               pc_n    = pc4;
               addr_n  = pc4;
            end else if (done) begin
               skid_v_n     = 1'b1;
               skid_instr_n = imem_rdata;
               skid_pc4_n   = pc4;
               pc_n         = pc4;
               state_n      = WAIT;
            end
         end
         DRAIN: begin
            pc_n    = redir ? tgt_al : pc;
            state_n = done ? FETCH : DRAIN;
            addr_n  = done ? pc_n : imem_addr;
         end
         WAIT: begin
            if (redir) begin
               pc_n    = tgt_al;
               addr_n  = tgt_al;
               state_n = FETCH;
            end else if (!stall) begin
               instr_n  = skid_instr;
               pc4_n    = skid_pc4;
               valid_n  = 1'b1;
               skid_v_n = 1'b0;
               addr_n   = pc;
               state_n  = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
      // a redirect squashes everything already fetched on the old path
      if (redir) begin
         valid_n  = 1'b0;
         skid_v_n = 1'b0;
      end
   end
endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
- Program-counter sequencer and instruction-fetch front end for the single-issue MIPS core.
- Consumes the branch and jump targets produced by the branch/jump address logic, owns the PC register and issues word fetches to instruction memory over a req/ready handshake.
- Presents fetched instructions, plus PC+4, to decode. PC+4 is the base the branch/jump address logic uses.
- No branch delay slot: a redirect flushes the fetched-but-unconsumed instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
br_taken  input  1  branch resolved taken this cycle
br_target  input  32  branch target address
jump_en  input  1  jump this cycle
jump_target  input  32  jump target address
stall  input  1  decode cannot accept; hold if_* outputs
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address
imem_ready  input  1  memory returns imem_rdata this cycle for the held request
imem_rdata  input  32  instruction word
if_valid  output  1  if_instr/if_pc_plus4 valid
if_instr  output  32  fetched instruction
if_pc_plus4  output  32  address of if_instr + 4
addr_err  output  1  one-cycle pulse: redirect target had [1:0]!=0

Behaviour:
- Reset (async assert, sync deassert):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_plus4=0, addr_err=0.
  - Skid buffer empty.
- Handshake:
  - A fetch completes on a cycle with imem_req=1 and imem_ready=1.
  - While imem_req=1 and the fetch is not complete, imem_addr is held stable and imem_req is not dropped.
  - imem_addr equals pc whenever a new request starts.
- Redirect:
  - jump_en has priority over br_taken.
  - Target bits [1:0] are forced to 00; addr_err pulses on the next cycle if they were nonzero.
  - Redirect clears if_valid and the skid buffer next cycle, regardless of stall.
- IDLE: next cycle -> FETCH, imem_req=1, imem_addr=pc.
- FETCH, on completion:
  - No redirect, and (stall=0 or if_valid=0):
    - if_instr<=imem_rdata, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4.
    - New request issued the next cycle at the new pc; throughput is 1 instruction/cycle with a zero-wait memory.
  - No redirect, stall=1 and if_valid=1:
    - Word and pc+4 captured into the 1-entry skid buffer, pc<=pc+4, -> WAIT, imem_req=0.
  - Redirect in the same cycle: returned word discarded, pc<=target, next request at target.
- FETCH, redirect without completion:
  - pc<=target, -> DRAIN.
  - imem_req stays high at the old address until ready; returned data is discarded.
  - Then -> FETCH at pc.
- DRAIN, further redirect: pc<=newest target. Last redirect wins.
- WAIT:
  - When stall=0: skid contents move to if_*, skid empties, -> FETCH at pc.
  - Redirect in WAIT: skid and if_valid cleared, pc<=target, -> FETCH.
- Stall hold: with if_valid=1 and stall=1, if_instr and if_pc_plus4 are held unchanged.
- Consume: with stall=0 and no new word landing, if_valid<=0 the cycle after the instruction is consumed.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no error.
- Reset mid-request: imem_req drops immediately (async); the outstanding memory response is ignored.

Test Plan:
- Reset RESET_PC=0x0040_0000, imem_ready tied 1 -> imem_addr 0x400000, 0x400004, 0x400008 on consecutive cycles; if_pc_plus4 = 0x400004, 0x400008, ...
- imem_ready delayed 3 cycles -> imem_addr/imem_req stable for 4 cycles; if_valid high only after ready.
- br_taken with br_target=0x0040_0100 during an outstanding slow fetch:
  - old word discarded, if_valid=0.
  - Next request addr 0x400100.
  - Same case with jump_en=1, jump_target=0x0040_0200 -> 0x400200 (jump wins).
- stall raised while a fetch completes:
  - if_instr held; new word goes to skid; imem_req=0.
  - stall low -> skid word appears, fetch resumes at the correct pc, no instruction lost or duplicated.
- jump_target=0x0040_0102 -> fetch at 0x400100, addr_err pulses exactly one cycle.
- pc=0xFFFF_FFFC fetch -> next imem_addr 0x0000_0000; rst_n asserted mid-request -> imem_req=0 same cycle, outputs at reset values.
